// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction memory loader.
//   HDR_BYTES      - bytes of frame header (the word count)
//   BYTES_PER_WORD - host bytes packed into one instruction word
//   state_t        - loader FSM state encoding
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds the ST_CSUM state.
package imem_loader_pkg;

    localparam int HDR_BYTES      = 1;
    localparam int BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_BYTE_HI = 3'd2,
        ST_BYTE_LO = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
        , ST_CSUM  = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: assembles two host bytes into one big-endian
// instruction word.
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   load_hi, load_lo  - capture byte_in into the high / low half
//   byte_in           - host byte
//   word              - {high byte, low byte}
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_hi,
    input  logic                          load_lo,
    input  logic [7:0]                    byte_in,
    output logic [8*BYTES_PER_WORD-1:0]   word
);

    logic [7:0] hi_q;
    logic [7:0] lo_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (load_hi) hi_q <= byte_in;
            if (load_lo) lo_q <= byte_in;
        end
    end

    assign word = {hi_q, lo_q};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed host byte stream and
// holds the CPU stalled until a load has completed.
// Frame: header byte N (0 means 2^ADDR_W words), then N big-endian word pairs.
// Ports:
//   clock, reset              - system clock, synchronous active-high reset
//   load_req                  - start a load (honoured only when idle)
//   in_valid, in_data, in_ready - host byte handshake
//   mem_we, mem_address, mem_write_data - instruction memory write port
//   cpu_hold                  - high keeps the CPU stalled
//   busy                      - load in progress
//   load_done                 - one-cycle pulse at end of a load
//   words_loaded              - words written in current / last load
//   load_error (optional)     - checksum mismatch on the last load
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
// (XOR of header and data bytes) and the load_error port.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for load_req, host stalled
// ST_HDR     | accepting the word-count header byte
// ST_BYTE_HI | accepting the high byte of a word
// ST_BYTE_LO | accepting the low byte of a word
// ST_WRITE   | one-cycle memory write of the assembled word
// ST_CSUM    | accepting the checksum byte (checksum build only)
// ST_DONE    | one-cycle load_done pulse, CPU hold released
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8 * BYTES_PER_WORD,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic [ADDR_W:0]   words_loaded
`ifdef IMEM_LOADER_CHECKSUM_EN
    , output logic            load_error
`endif
);

    localparam int CNT_W = ADDR_W + 1;

    state_t                 state;
    logic [ADDR_W-1:0]      addr;
    logic [CNT_W-1:0]       target;
    logic [CNT_W-1:0]       words_next;
    logic [8*HDR_BYTES-1:0] hdr_byte;
    logic                   byte_take;
    logic                   load_hi;
    logic                   load_lo;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             csum;
`endif

    assign byte_take   = in_valid && in_ready;
    assign load_hi     = byte_take && (state == ST_BYTE_HI);
    assign load_lo     = byte_take && (state == ST_BYTE_LO);
    assign hdr_byte    = in_data;
    assign words_next  = words_loaded + CNT_W'(1);
    assign mem_address = addr;

    imem_loader_byte_packer u_packer (
        .clock   (clock),
        .reset   (reset),
        .load_hi (load_hi),
        .load_lo (load_lo),
        .byte_in (in_data),
        .word    (mem_write_data)
    );

    // in_ready and busy are registered alongside every state change so they
    // always match the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            addr         <= BASE_ADDR;
            target       <= '0;
            words_loaded <= '0;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            load_done    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
            load_error   <= 1'b0;
`endif
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_req) begin
                        state        <= ST_HDR;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        words_loaded <= '0;
                        addr         <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        load_error   <= 1'b0;
`endif
                    end
                end
                ST_HDR: begin
                    if (byte_take) begin
                        // A zero header means a full memory image.
                        target <= (hdr_byte == '0) ? (CNT_W'(1) << ADDR_W)
                                                   : CNT_W'(hdr_byte);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum   <= in_data;
`endif
                        state  <= ST_BYTE_HI;
                    end
                end
                ST_BYTE_HI: begin
                    if (byte_take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum  <= csum ^ in_data;
`endif
                        state <= ST_BYTE_LO;
                    end
                end
                ST_BYTE_LO: begin
                    if (byte_take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        state    <= ST_WRITE;
                        in_ready <= 1'b0;
                        mem_we   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    addr         <= addr + 1'b1;
                    words_loaded <= words_next;
                    if (words_next == target) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state     <= ST_CSUM;
                        in_ready  <= 1'b1;
`else
                        state     <= ST_DONE;
                        load_done <= 1'b1;
`endif
                    end else begin
                        state    <= ST_BYTE_HI;
                        in_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (byte_take) begin
                        load_error <= (in_data != csum);
                        state      <= ST_DONE;
                        in_ready   <= 1'b0;
                        load_done  <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    // A bad image keeps the CPU stalled.
                    cpu_hold <= load_error;
`else
                    cpu_hold <= 1'b0;
`endif
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic [8:0] words;
        logic       hold;
        logic       err;
    } done_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_req;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_address;
    logic [15:0] mem_write_data;
    logic        cpu_hold;
    logic        busy;
    logic        load_done;
    logic [8:0]  words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        load_error;
`endif

    int total = 0;
    int bad   = 0;

    wr_t   wr_q[$];
    done_t done_q[$];
    logic  hold_pending = 1'b0;
    logic  hold_exp     = 1'b0;

    imem_loader dut (
        .clock          (clock),
        .reset          (reset),
        .load_req       (load_req),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .cpu_hold       (cpu_hold),
        .busy           (busy),
        .load_done      (load_done),
        .words_loaded   (words_loaded)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .load_error   (load_error)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or finishes.
    always @(negedge clock) begin
        wr_t   w;
        done_t d;
        if (hold_pending) begin
            check("cpu_hold_after_done", 32'(cpu_hold), 32'(hold_exp));
            hold_pending = 1'b0;
        end
        if (mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", 32'(mem_address), 32'(w.addr));
                check("wr_data", 32'(mem_write_data), 32'(w.data));
            end
        end
        if (load_done === 1'b1) begin
            if (done_q.size() == 0) begin
                fail_now("unexpected_load_done");
            end else begin
                d = done_q.pop_front();
                check("done_words", 32'(words_loaded), 32'(d.words));
                check("hold_during_done", 32'(cpu_hold), 32'(1));
`ifdef IMEM_LOADER_CHECKSUM_EN
                check("load_error", 32'(load_error), 32'(d.err));
`endif
                hold_exp     = d.hold;
                hold_pending = 1'b1;
            end
        end
    end

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (in_ready !== 1'b1) fail_now("byte_accept");
        else @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] bs[], input int gap);
        foreach (bs[i]) send_byte(bs[i], gap);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((wr_q.size() != 0 || done_q.size() != 0) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (wr_q.size() != 0 || done_q.size() != 0) fail_now("drain");
        repeat (2) @(negedge clock);
    endtask

    initial begin
        logic [7:0] f[];
        logic [7:0] hi;
        logic [7:0] lo;
        reset    = 1'b1;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Idle with bytes offered: nothing may be accepted.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (10) @(negedge clock);
        check("idle_cpu_hold", 32'(cpu_hold), 32'(1));
        check("idle_mem_we", 32'(mem_we), 32'(0));
        check("idle_in_ready", 32'(in_ready), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_words", 32'(words_loaded), 32'(0));
        check("idle_load_done", 32'(load_done), 32'(0));
        in_valid = 1'b0;

        // Two words, back-to-back bytes.
        wr_q.push_back('{8'h00, 16'h1234});
        wr_q.push_back('{8'h01, 16'hABCD});
        done_q.push_back('{9'd2, 1'b0, 1'b0});
        pulse_load_req();
        check("busy_after_req", 32'(busy), 32'(1));
        f = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_frame(f, 0);
        drain();
        check("busy_after_load", 32'(busy), 32'(0));

        // One word with gaps; a load_req mid-frame must be ignored.
        wr_q.push_back('{8'h00, 16'hBEEF});
        done_q.push_back('{9'd1, 1'b0, 1'b0});
        pulse_load_req();
        check("hold_on_new_load", 32'(cpu_hold), 32'(1));
        send_byte(8'h01, 3);
        in_valid = 1'b0;
        pulse_load_req();
        send_byte(8'hBE, 3);
        send_byte(8'hEF, 3);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of word 1 of a 3-word load.
        wr_q.push_back('{8'h00, 16'h1122});
        pulse_load_req();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cpu_hold", 32'(cpu_hold), 32'(1));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_words", 32'(words_loaded), 32'(0));
        check("rst_pending_writes", 32'(wr_q.size()), 32'(0));
        wr_q.push_back('{8'h00, 16'h0007});
        done_q.push_back('{9'd1, 1'b0, 1'b0});
        pulse_load_req();
        f = '{8'h01, 8'h00, 8'h07};
        send_frame(f, 0);
        drain();

        // Header 0: full 256-word image, address wraps back to 0.
        pulse_load_req();
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            hi = 8'(i);
            lo = 8'(i) ^ 8'h5A;
            wr_q.push_back('{8'(i), {hi, lo}});
            if (i == 255) done_q.push_back('{9'd256, 1'b0, 1'b0});
            send_byte(hi, 0);
            send_byte(lo, 0);
        end
        in_valid = 1'b0;
        drain();
        check("addr_wrap", 32'(mem_address), 32'(0));
        check("full_words", 32'(words_loaded), 32'(256));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Good checksum: 01^12^34 = 27.
        wr_q.push_back('{8'h00, 16'h1234});
        done_q.push_back('{9'd1, 1'b0, 1'b0});
        pulse_load_req();
        f = '{8'h01, 8'h12, 8'h34, 8'h27};
        send_frame(f, 0);
        drain();
        check("csum_ok_error", 32'(load_error), 32'(0));

        // Bad checksum: CPU stays held, error latched.
        wr_q.push_back('{8'h00, 16'h1234});
        done_q.push_back('{9'd1, 1'b1, 1'b1});
        pulse_load_req();
        f = '{8'h01, 8'h12, 8'h34, 8'h00};
        send_frame(f, 0);
        drain();
        check("csum_bad_error", 32'(load_error), 32'(1));
        check("csum_bad_hold", 32'(cpu_hold), 32'(1));
`endif

        check("final_wr_q_empty", 32'(wr_q.size()), 32'(0));
        check("final_done_q_empty", 32'(done_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
